// File: rtl/score_display_ctrl.sv
// Score HUD glyph sequencer: converts score/combo to decimal once per frame, fetches one glyph
// per visible digit through a shared lookup port, and commits all five glyphs to the outputs together.
module score_display_ctrl #(
  parameter int TIMEOUT   = 16,
  parameter int COMBO_MAX = 99
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_clk,
  input  logic [7:0]   total_Score,
  input  logic [7:0]   combo,
  output logic         glyph_req,
  output logic [3:0]   glyph_digit,
  input  logic [349:0] glyph_bits,
  input  logic         glyph_valid,
  output logic [349:0] score_hund_color,
  output logic [349:0] score_ten_color,
  output logic [349:0] score_one_color,
  output logic [349:0] combo_ten_color,
  output logic [349:0] combo_one_color,
  output logic         busy,
  output logic         frame_done,
  output logic         timeout_err
);

  localparam int NSLOT = 5;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    COMBO_SAT    = 8'(COMBO_MAX);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_CONVERT = 3'd2;
  localparam logic [2:0] ST_FETCH   = 3'd3;
  localparam logic [2:0] ST_COMMIT  = 3'd4;

  logic [2:0]    sync_reg;
  logic          frame_edge;
  logic [2:0]    state_reg;
  logic          pending_reg;
  logic [7:0]    s_rem_reg, c_rem_reg;
  logic [3:0]    s_h_reg, s_t_reg, c_t_reg;
  logic [2:0]    slot_reg;
  logic          req_reg;
  logic [TW-1:0] timer_reg;
  logic          timeout_err_reg;
  logic          frame_done_reg;

  logic [7:0]    s_rem_next, c_rem_next;
  logic [3:0]    s_h_next, s_t_next, c_t_next;
  logic          s_moved, c_moved;
  logic [3:0]    slot_digit;
  logic          slot_blank;
  logic          shadow_load;
  logic [349:0]  shadow_data;
  logic          timeout_hit;

  // Bits 0/1 are the two synchronizer flops; bit 2 is the previous value for edge detection.
  assign frame_edge = sync_reg[1] & ~sync_reg[2];

  always_comb begin
    s_rem_next = s_rem_reg;
    s_h_next   = s_h_reg;
    s_t_next   = s_t_reg;
    s_moved    = 1'b0;
    if (s_rem_reg >= 8'd100) begin
      s_rem_next = s_rem_reg - 8'd100;
      s_h_next   = s_h_reg + 4'd1;
      s_moved    = 1'b1;
    end else if (s_rem_reg >= 8'd10) begin
      s_rem_next = s_rem_reg - 8'd10;
      s_t_next   = s_t_reg + 4'd1;
      s_moved    = 1'b1;
    end
    c_rem_next = c_rem_reg;
    c_t_next   = c_t_reg;
    c_moved    = 1'b0;
    if (c_rem_reg >= 8'd10) begin
      c_rem_next = c_rem_reg - 8'd10;
      c_t_next   = c_t_reg + 4'd1;
      c_moved    = 1'b1;
    end
  end

  // Slot order: score hundreds, score tens, score ones, combo tens, combo ones.
  always_comb begin
    slot_digit = 4'd0;
    slot_blank = 1'b0;
    case (slot_reg)
      3'd0: begin
        slot_digit = s_h_reg;
        slot_blank = (s_h_reg == 4'd0);
      end
      3'd1: begin
        slot_digit = s_t_reg;
        slot_blank = (s_h_reg == 4'd0) && (s_t_reg == 4'd0);
      end
      3'd2: slot_digit = s_rem_reg[3:0];
      3'd3: begin
        slot_digit = c_t_reg;
        slot_blank = (c_t_reg == 4'd0);
      end
      default: slot_digit = c_rem_reg[3:0];
    endcase
  end

  // A slot finishes on blank, on a returned glyph, or on timeout; blank and timeout load zeros.
  always_comb begin
    shadow_load = 1'b0;
    shadow_data = '0;
    timeout_hit = 1'b0;
    if (state_reg == ST_FETCH) begin
      if (slot_blank) begin
        shadow_load = 1'b1;
      end else if (req_reg && glyph_valid) begin
        shadow_load = 1'b1;
        shadow_data = glyph_bits;
      end else if (req_reg && (timer_reg == TIMEOUT_LAST)) begin
        shadow_load = 1'b1;
        timeout_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_reg        <= '0;
      state_reg       <= ST_IDLE;
      pending_reg     <= 1'b0;
      s_rem_reg       <= '0;
      s_h_reg         <= '0;
      s_t_reg         <= '0;
      c_rem_reg       <= '0;
      c_t_reg         <= '0;
      slot_reg        <= '0;
      req_reg         <= 1'b0;
      timer_reg       <= '0;
      timeout_err_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[1:0], frame_clk};
      frame_done_reg <= 1'b0;
      if (frame_edge && (state_reg != ST_IDLE)) begin
        pending_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (frame_edge) begin
            state_reg <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          s_rem_reg <= total_Score;
          s_h_reg   <= 4'd0;
          s_t_reg   <= 4'd0;
          c_rem_reg <= (combo > COMBO_SAT) ? COMBO_SAT : combo;
          c_t_reg   <= 4'd0;
          state_reg <= ST_CONVERT;
        end
        ST_CONVERT: begin
          s_rem_reg <= s_rem_next;
          s_h_reg   <= s_h_next;
          s_t_reg   <= s_t_next;
          c_rem_reg <= c_rem_next;
          c_t_reg   <= c_t_next;
          if (!s_moved && !c_moved) begin
            state_reg <= ST_FETCH;
            slot_reg  <= 3'd0;
            req_reg   <= 1'b0;
            timer_reg <= '0;
          end
        end
        ST_FETCH: begin
          if (shadow_load) begin
            req_reg <= 1'b0;
            if (timeout_hit) begin
              timeout_err_reg <= 1'b1;
            end
            if (slot_reg == 3'(NSLOT - 1)) begin
              state_reg <= ST_COMMIT;
            end else begin
              slot_reg <= slot_reg + 3'd1;
            end
          end else if (!req_reg) begin
            req_reg   <= 1'b1;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_COMMIT: begin
          frame_done_reg <= 1'b1;
          // An edge arriving in this very cycle counts as pending too.
          if (pending_reg || frame_edge) begin
            pending_reg <= 1'b0;
            state_reg   <= ST_CAPTURE;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      logic [349:0] shadow_reg;
      logic [349:0] color_reg;
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          shadow_reg <= '0;
          color_reg  <= '0;
        end else begin
          if (shadow_load && (slot_reg == 3'(gi))) begin
            shadow_reg <= shadow_data;
          end
          if (state_reg == ST_COMMIT) begin
            color_reg <= shadow_reg;
          end
        end
      end
    end
  endgenerate

  assign score_hund_color = g_slot[0].color_reg;
  assign score_ten_color  = g_slot[1].color_reg;
  assign score_one_color  = g_slot[2].color_reg;
  assign combo_ten_color  = g_slot[3].color_reg;
  assign combo_one_color  = g_slot[4].color_reg;

  assign glyph_req   = req_reg;
  assign glyph_digit = req_reg ? slot_digit : 4'd0;
  assign busy        = (state_reg != ST_IDLE);
  assign frame_done  = frame_done_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a behavioural glyph lookup of configurable latency.
module tb_score_display_ctrl;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         frame_clk = 1'b0;
  logic [7:0]   total_Score = 8'd0;
  logic [7:0]   combo = 8'd0;
  logic         glyph_req;
  logic [3:0]   glyph_digit;
  logic [349:0] glyph_bits = '0;
  logic         glyph_valid = 1'b0;
  logic [349:0] score_hund_color, score_ten_color, score_one_color;
  logic [349:0] combo_ten_color, combo_one_color;
  logic         busy, frame_done, timeout_err;

  int checks = 0;
  int failures = 0;

  score_display_ctrl #(.TIMEOUT(16), .COMBO_MAX(99)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .total_Score(total_Score), .combo(combo),
    .glyph_req(glyph_req), .glyph_digit(glyph_digit),
    .glyph_bits(glyph_bits), .glyph_valid(glyph_valid),
    .score_hund_color(score_hund_color), .score_ten_color(score_ten_color),
    .score_one_color(score_one_color), .combo_ten_color(combo_ten_color),
    .combo_one_color(combo_one_color),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [349:0] glyph_of(input int d);
    logic [349:0] g;
    for (int i = 0; i < 350; i++) g[i] = (((i * 7 + d * 13) % 11) < 5);
    g[349:346] = d[3:0];
    return g;
  endfunction

  // Lookup model: answers after 'lat' request cycles unless the digit is blocked.
  int lat = 1;
  int block_digit = -1;
  int wait_cnt = 0;
  logic [39:0] fetch_seq = '0;
  int fetch_cnt = 0;
  always @(negedge Clk) begin
    if (glyph_valid) begin
      glyph_valid = 1'b0;
      wait_cnt = 0;
    end else if (glyph_req && (int'(glyph_digit) != block_digit)) begin
      if (wait_cnt >= lat - 1) begin
        glyph_valid = 1'b1;
        glyph_bits = glyph_of(int'(glyph_digit));
        fetch_seq = {fetch_seq[35:0], glyph_digit};
        fetch_cnt++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  int done_cnt = 0;
  int req4_cnt = 0;
  int partial_err = 0;
  logic [1749:0] cur_colors, prev_colors = '0;
  always @(negedge Clk) begin
    cur_colors = {score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color};
    if (frame_done) done_cnt++;
    if (glyph_req && glyph_digit == 4'd4) req4_cnt++;
    if (Reset && (cur_colors !== prev_colors) && !frame_done) partial_err++;
    prev_colors = cur_colors;
  end

  logic [349:0] e0, e1, e2, e3, e4;

  task automatic run_frame(input string tag);
    int start;
    start = done_cnt;
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    for (int i = 0; i < 800 && done_cnt == start; i++) @(negedge Clk);
    checks++;
    if (done_cnt == start) begin
      failures++;
      $display("FAIL %s_frame_done got_pulses=0 required=1", tag);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    int start;
    Reset = 1'b0; total_Score = 8'd0; combo = 8'd0; frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== '0) begin
      failures++; $display("FAIL reset_colors got=nonzero required=0");
    end
    checks++; if (glyph_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b required=0", glyph_req); end
    checks++; if (glyph_digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d required=0", glyph_digit); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b required=0", frame_done); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", timeout_err); end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    fetch_cnt = 0; fetch_seq = '0; start = done_cnt;
    // Edge reaches CAPTURE on the third rising Clk edge.
    frame_clk = 1'b1;
    @(negedge Clk); @(negedge Clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sync_early busy=%b required=0", busy); end
    @(negedge Clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sync_capture busy=%b required=1", busy); end
    frame_clk = 1'b0;
    for (int i = 0; i < 800 && done_cnt == start; i++) @(negedge Clk);
    repeat (20) @(negedge Clk);
    checks++; if (done_cnt - start != 1) begin failures++; $display("FAIL zero_done_pulses got=%0d required=1", done_cnt - start); end
    checks++;
    if (fetch_cnt != 2 || fetch_seq[7:0] !== 8'h00) begin
      failures++; $display("FAIL zero_fetches got_cnt=%0d seq=%0h required_cnt=2 seq=00", fetch_cnt, fetch_seq);
    end
    e0 = '0; e1 = '0; e2 = glyph_of(0); e3 = '0; e4 = glyph_of(0);
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== {e0, e1, e2, e3, e4}) begin
      failures++;
      $display("FAIL zero_colors slot_ok=%b%b%b%b%b required=11111", score_hund_color === e0,
               score_ten_color === e1, score_one_color === e2, combo_ten_color === e3, combo_one_color === e4);
    end
  endtask

  task automatic test_convert();
    int start, n;
    total_Score = 8'd255; combo = 8'd37; lat = 1;
    fetch_cnt = 0; fetch_seq = '0; start = done_cnt; n = 0;
    frame_clk = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) @(negedge Clk);
    // From CAPTURE: 8 CONVERT cycles, one slot-issue cycle, then glyph_req is seen high.
    for (int i = 0; i < 60 && !glyph_req; i++) begin
      @(negedge Clk);
      n++;
    end
    checks++; if (n != 10) begin failures++; $display("FAIL convert_len got=%0d required=10", n); end
    frame_clk = 1'b0;
    for (int i = 0; i < 800 && done_cnt == start; i++) @(negedge Clk);
    repeat (3) @(negedge Clk);
    checks++; if (done_cnt - start != 1) begin failures++; $display("FAIL conv_done got=%0d required=1", done_cnt - start); end
    checks++;
    if (fetch_cnt != 5 || fetch_seq[19:0] !== 20'h25537) begin
      failures++; $display("FAIL conv_fetches got_cnt=%0d seq=%0h required_cnt=5 seq=25537", fetch_cnt, fetch_seq);
    end
    e0 = glyph_of(2); e1 = glyph_of(5); e2 = glyph_of(5); e3 = glyph_of(3); e4 = glyph_of(7);
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== {e0, e1, e2, e3, e4}) begin
      failures++;
      $display("FAIL conv_colors slot_ok=%b%b%b%b%b required=11111", score_hund_color === e0,
               score_ten_color === e1, score_one_color === e2, combo_ten_color === e3, combo_one_color === e4);
    end
  endtask

  task automatic test_saturation();
    total_Score = 8'd7; combo = 8'd200;
    fetch_cnt = 0; fetch_seq = '0;
    run_frame("sat");
    checks++;
    if (fetch_cnt != 3 || fetch_seq[11:0] !== 12'h799) begin
      failures++; $display("FAIL sat_fetches got_cnt=%0d seq=%0h required_cnt=3 seq=799", fetch_cnt, fetch_seq);
    end
    e0 = '0; e1 = '0; e2 = glyph_of(7); e3 = glyph_of(9); e4 = glyph_of(9);
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== {e0, e1, e2, e3, e4}) begin
      failures++;
      $display("FAIL sat_colors slot_ok=%b%b%b%b%b required=11111", score_hund_color === e0,
               score_ten_color === e1, score_one_color === e2, combo_ten_color === e3, combo_one_color === e4);
    end
  endtask

  task automatic test_timeout();
    total_Score = 8'd42; combo = 8'd5; block_digit = 4;
    fetch_cnt = 0; fetch_seq = '0; req4_cnt = 0;
    run_frame("tmo");
    block_digit = -1;
    checks++; if (req4_cnt != 16) begin failures++; $display("FAIL tmo_req_cycles got=%0d required=16", req4_cnt); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b required=1", timeout_err); end
    checks++;
    if (fetch_cnt != 2 || fetch_seq[7:0] !== 8'h25) begin
      failures++; $display("FAIL tmo_fetches got_cnt=%0d seq=%0h required_cnt=2 seq=25", fetch_cnt, fetch_seq);
    end
    e0 = '0; e1 = '0; e2 = glyph_of(2); e3 = '0; e4 = glyph_of(5);
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== {e0, e1, e2, e3, e4}) begin
      failures++;
      $display("FAIL tmo_colors slot_ok=%b%b%b%b%b required=11111", score_hund_color === e0,
               score_ten_color === e1, score_one_color === e2, combo_ten_color === e3, combo_one_color === e4);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    total_Score = 8'd123; combo = 8'd45; lat = 6;
    fetch_cnt = 0; fetch_seq = '0; start = done_cnt;
    frame_clk = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      frame_clk = 1'b1; repeat (3) @(negedge Clk);
      frame_clk = 1'b0; repeat (3) @(negedge Clk);
    end
    for (int i = 0; i < 800 && done_cnt - start < 2; i++) @(negedge Clk);
    repeat (80) @(negedge Clk);
    lat = 1;
    checks++; if (done_cnt - start != 2) begin failures++; $display("FAIL b2b_done got=%0d required=2", done_cnt - start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle busy=%b required=0", busy); end
    checks++;
    if (fetch_cnt != 10 || fetch_seq !== 40'h1234512345) begin
      failures++; $display("FAIL b2b_fetches got_cnt=%0d seq=%0h required_cnt=10 seq=1234512345", fetch_cnt, fetch_seq);
    end
    e0 = glyph_of(1); e1 = glyph_of(2); e2 = glyph_of(3); e3 = glyph_of(4); e4 = glyph_of(5);
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== {e0, e1, e2, e3, e4}) begin
      failures++;
      $display("FAIL b2b_colors slot_ok=%b%b%b%b%b required=11111", score_hund_color === e0,
               score_ten_color === e1, score_one_color === e2, combo_ten_color === e3, combo_one_color === e4);
    end
  endtask

  task automatic test_score_change();
    int start;
    total_Score = 8'd200; combo = 8'd11; lat = 3;
    fetch_cnt = 0; fetch_seq = '0; start = done_cnt;
    frame_clk = 1'b1;
    for (int i = 0; i < 100 && !glyph_req; i++) @(negedge Clk);
    frame_clk = 1'b0;
    total_Score = 8'd99; combo = 8'd50;
    for (int i = 0; i < 800 && done_cnt == start; i++) @(negedge Clk);
    repeat (3) @(negedge Clk);
    lat = 1;
    checks++;
    if (fetch_cnt != 5 || fetch_seq[19:0] !== 20'h20011) begin
      failures++; $display("FAIL chg_fetches got_cnt=%0d seq=%0h required_cnt=5 seq=20011", fetch_cnt, fetch_seq);
    end
    e0 = glyph_of(2); e1 = glyph_of(0); e2 = glyph_of(0); e3 = glyph_of(1); e4 = glyph_of(1);
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== {e0, e1, e2, e3, e4}) begin
      failures++;
      $display("FAIL chg_colors slot_ok=%b%b%b%b%b required=11111", score_hund_color === e0,
               score_ten_color === e1, score_one_color === e2, combo_ten_color === e3, combo_one_color === e4);
    end
    checks++; if (partial_err != 0) begin failures++; $display("FAIL chg_partial got=%0d required=0", partial_err); end
  endtask

  task automatic test_reset_midfetch();
    total_Score = 8'd88; combo = 8'd3; lat = 4;
    frame_clk = 1'b1;
    for (int i = 0; i < 100 && !glyph_req; i++) @(negedge Clk);
    frame_clk = 1'b0;
    checks++; if (glyph_req !== 1'b1) begin failures++; $display("FAIL mid_reached_fetch req=%b required=1", glyph_req); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (glyph_req !== 1'b0) begin failures++; $display("FAIL mid_req got=%b required=0", glyph_req); end
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== '0) begin
      failures++; $display("FAIL mid_colors got=nonzero required=0");
    end
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL mid_flags busy=%b err=%b required=0,0", busy, timeout_err); end
    repeat (3) @(negedge Clk);
    Reset = 1'b1; lat = 1;
    repeat (3) @(negedge Clk);
    fetch_cnt = 0; fetch_seq = '0;
    run_frame("mid");
    checks++;
    if (fetch_cnt != 3 || fetch_seq[11:0] !== 12'h883) begin
      failures++; $display("FAIL mid_fetches got_cnt=%0d seq=%0h required_cnt=3 seq=883", fetch_cnt, fetch_seq);
    end
    e0 = '0; e1 = glyph_of(8); e2 = glyph_of(8); e3 = '0; e4 = glyph_of(3);
    checks++;
    if ({score_hund_color, score_ten_color, score_one_color, combo_ten_color, combo_one_color} !== {e0, e1, e2, e3, e4}) begin
      failures++;
      $display("FAIL mid_colors_after slot_ok=%b%b%b%b%b required=11111", score_hund_color === e0,
               score_ten_color === e1, score_one_color === e2, combo_ten_color === e3, combo_one_color === e4);
    end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL mid_err_after got=%b required=0", timeout_err); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_saturation();
    test_timeout();
    test_back_to_back();
    test_score_change();
    test_reset_midfetch();
    checks++; if (partial_err != 0) begin failures++; $display("FAIL final_partial got=%0d required=0", partial_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
